// File: rtl/render_pkg.sv
// Shared rendering types: scheduler state encoding and fixed-point word width.
package render_pkg;

  localparam int FIX_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_PRESENT = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } sched_state_t;

endpackage

// File: rtl/read_latency_pipe.sv
// Delays the position-memory read strobe by DEPTH cycles so that the
// scheduler knows when mem_*_in carries the requested particle.
module read_latency_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic rd_en,
  output logic rd_valid
);

  logic [DEPTH-1:0] shift_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
    end else begin
      shift_q[0] <= rd_en;
      for (int i = 1; i < DEPTH; i++) begin
        shift_q[i] <= shift_q[i-1];
      end
    end
  end

  assign rd_valid = shift_q[DEPTH-1];

endmodule

// File: rtl/projection_scheduler.sv
// Walks a frame's particles: reads each position from memory, hands it to the
// projector over a valid/ready link, and counts projector completions.
module projection_scheduler
  import render_pkg::*;
#(
  parameter int NUM_PARTICLES = 64,
  parameter int ADDR_WIDTH    = $clog2(NUM_PARTICLES),
  parameter int READ_LATENCY  = 2
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   frame_start_in,
  input  logic [ADDR_WIDTH:0]    particle_count_in,
  output logic                   mem_rd_en_out,
  output logic [ADDR_WIDTH-1:0]  mem_addr_out,
  input  logic [FIX_WIDTH-1:0]   mem_x_in,
  input  logic [FIX_WIDTH-1:0]   mem_y_in,
  input  logic [FIX_WIDTH-1:0]   mem_z_in,
  output logic                   proj_valid_out,
  input  logic                   proj_ready_in,
  output logic [FIX_WIDTH-1:0]   proj_x_out,
  output logic [FIX_WIDTH-1:0]   proj_y_out,
  output logic [FIX_WIDTH-1:0]   proj_z_out,
  input  logic                   proj_done_in,
  output logic                   busy_out,
  output logic                   frame_done_out,
  output logic                   overrun_out,
  output logic [ADDR_WIDTH:0]    issued_count_out,
  output logic [ADDR_WIDTH:0]    completed_count_out
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] MAX_COUNT = CW'(NUM_PARTICLES);

  sched_state_t          state_q, state_d;
  logic [1:0]            rst_sync_q;
  logic                  rst_n;
  logic [ADDR_WIDTH:0]   count_q;
  logic [ADDR_WIDTH:0]   issued_q;
  logic [ADDR_WIDTH:0]   completed_q;
  logic [ADDR_WIDTH:0]   issued_inc;
  logic [ADDR_WIDTH:0]   count_clamped;
  logic [ADDR_WIDTH-1:0] index_q;
  logic [FIX_WIDTH-1:0]  px_q, py_q, pz_q;
  logic                  rd_pending_q;
  logic                  rd_valid;
  logic                  frame_done_q;
  logic                  overrun_q;
  logic                  start_accept;
  logic                  transfer;

  // Reset asserts asynchronously but is released only on a clock edge.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  read_latency_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_read_latency_pipe (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .rd_en    (mem_rd_en_out),
    .rd_valid (rd_valid)
  );

  // Projector link: a position moves when proj_valid_out and proj_ready_in are
  // both high at a rising edge. Valid is raised only in PRESENT, data is held
  // stable until that transfer, and valid drops the cycle after it.
  assign transfer      = (state_q == ST_PRESENT) && proj_ready_in;
  assign start_accept  = (state_q == ST_IDLE) && frame_start_in;
  assign issued_inc    = issued_q + CW'(1);
  assign count_clamped = (particle_count_in > MAX_COUNT) ? MAX_COUNT : particle_count_in;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (frame_start_in) begin
          state_d = (particle_count_in == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (rd_valid) state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (transfer) state_d = (issued_inc == count_q) ? ST_DRAIN : ST_FETCH;
      end
      ST_DRAIN: begin
        if (completed_q == count_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      issued_q    <= '0;
      completed_q <= '0;
      index_q     <= '0;
    end else if (start_accept) begin
      count_q     <= count_clamped;
      issued_q    <= '0;
      completed_q <= '0;
      index_q     <= '0;
    end else begin
      if (transfer) begin
        issued_q <= issued_inc;
        if (issued_inc != count_q) index_q <= index_q + ADDR_WIDTH'(1);
      end
      // Completions count only inside a frame and never past its size.
      if (proj_done_in && busy_out && (completed_q != count_q)) begin
        completed_q <= completed_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rd_pending_q <= 1'b0;
      px_q         <= '0;
      py_q         <= '0;
      pz_q         <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      if (mem_rd_en_out) begin
        rd_pending_q <= 1'b1;
      end else if (rd_valid) begin
        rd_pending_q <= 1'b0;
      end
      if ((state_q == ST_FETCH) && rd_valid) begin
        px_q <= mem_x_in;
        py_q <= mem_y_in;
        pz_q <= mem_z_in;
      end
      frame_done_q <= (state_q == ST_DONE);
      if (frame_start_in && (state_q != ST_IDLE)) overrun_q <= 1'b1;
    end
  end

  assign mem_rd_en_out       = (state_q == ST_FETCH) && !rd_pending_q;
  assign mem_addr_out        = index_q;
  assign proj_valid_out      = (state_q == ST_PRESENT);
  assign proj_x_out          = px_q;
  assign proj_y_out          = py_q;
  assign proj_z_out          = pz_q;
  assign busy_out            = (state_q == ST_FETCH) || (state_q == ST_PRESENT) ||
                               (state_q == ST_DRAIN);
  assign frame_done_out      = frame_done_q;
  assign overrun_out         = overrun_q;
  assign issued_count_out    = issued_q;
  assign completed_count_out = completed_q;

endmodule

// File: tb/tb_projection_scheduler.sv
// Directed bench for projection_scheduler: table of frame sizes plus
// hand-written sequences for backpressure, overrun, saturation and reset.
module tb_projection_scheduler;

  localparam int NP = 64;
  localparam int AW = 6;
  localparam int RL = 2;
  localparam int CW = AW + 1;

  logic          clk = 1'b0;
  logic          rst_n_in = 1'b1;
  logic          frame_start_in = 1'b0;
  logic [CW-1:0] particle_count_in = '0;
  logic          mem_rd_en_out;
  logic [AW-1:0] mem_addr_out;
  logic [15:0]   mem_x_in = 16'hDEAD;
  logic [15:0]   mem_y_in = 16'hDEAD;
  logic [15:0]   mem_z_in = 16'hDEAD;
  logic          proj_valid_out;
  logic          proj_ready_in = 1'b1;
  logic [15:0]   proj_x_out, proj_y_out, proj_z_out;
  logic          proj_done_in = 1'b0;
  logic          busy_out, frame_done_out, overrun_out;
  logic [CW-1:0] issued_count_out, completed_count_out;

  projection_scheduler #(
    .NUM_PARTICLES (NP),
    .ADDR_WIDTH    (AW),
    .READ_LATENCY  (RL)
  ) dut (
    .clk_in              (clk),
    .rst_n_in            (rst_n_in),
    .frame_start_in      (frame_start_in),
    .particle_count_in   (particle_count_in),
    .mem_rd_en_out       (mem_rd_en_out),
    .mem_addr_out        (mem_addr_out),
    .mem_x_in            (mem_x_in),
    .mem_y_in            (mem_y_in),
    .mem_z_in            (mem_z_in),
    .proj_valid_out      (proj_valid_out),
    .proj_ready_in       (proj_ready_in),
    .proj_x_out          (proj_x_out),
    .proj_y_out          (proj_y_out),
    .proj_z_out          (proj_z_out),
    .proj_done_in        (proj_done_in),
    .busy_out            (busy_out),
    .frame_done_out      (frame_done_out),
    .overrun_out         (overrun_out),
    .issued_count_out    (issued_count_out),
    .completed_count_out (completed_count_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // ---------------- scoreboard state ----------------
  logic [47:0] exp_q[$];
  int          done_q[$];
  int rd_cnt, last_addr, addr_errs, xfer_cnt, data_errs, proto_errs;
  int done_pulses, done_cyc, last_xfer_cyc, min_gap, valid_cnt;
  logic        rd_seen = 1'b0;
  logic [AW-1:0] addr_seen = '0;
  logic        s1v = 1'b0, s2v = 1'b0;
  logic [AW-1:0] s1a = '0, s2a = '0;
  logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_xfer = 1'b0;
  logic [47:0] prev_xyz = '0;

  function automatic logic [15:0] fx(input int a); return 16'(32'h1000 + a); endfunction
  function automatic logic [15:0] fy(input int a); return 16'(32'h2000 + a * 3); endfunction
  function automatic logic [15:0] fz(input int a); return 16'(32'h8000 + a * 5); endfunction

  function automatic logic [127:0] all_outs();
    return {mem_rd_en_out, mem_addr_out, proj_valid_out, proj_x_out, proj_y_out,
            proj_z_out, busy_out, frame_done_out, overrun_out, issued_count_out,
            completed_count_out};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory model (READ_LATENCY=2) and projector completion generator.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    s2v = s1v; s2a = s1a;
    s1v = rd_seen; s1a = addr_seen;
    mem_x_in = s2v ? fx(int'(s2a)) : 16'hDEAD;
    mem_y_in = s2v ? fy(int'(s2a)) : 16'hDEAD;
    mem_z_in = s2v ? fz(int'(s2a)) : 16'hDEAD;
    proj_done_in = 1'b0;
    if (done_q.size() > 0 && done_q[0] <= cyc) begin
      void'(done_q.pop_front());
      proj_done_in = 1'b1;
    end
  end

  // Monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [47:0] e;
    if (mem_rd_en_out) begin
      if (mem_addr_out != AW'(rd_cnt)) addr_errs++;
      last_addr = int'(mem_addr_out);
      rd_cnt++;
    end
    rd_seen   = mem_rd_en_out;
    addr_seen = mem_addr_out;
    if (proj_valid_out) valid_cnt++;
    if (prev_xfer && proj_valid_out) proto_errs++;
    if (prev_valid && !prev_ready &&
        (!proj_valid_out || {proj_x_out, proj_y_out, proj_z_out} != prev_xyz)) proto_errs++;
    prev_xfer = proj_valid_out && proj_ready_in;
    if (proj_valid_out && proj_ready_in) begin
      if (exp_q.size() == 0) begin
        data_errs++;
      end else begin
        e = exp_q.pop_front();
        if ({proj_x_out, proj_y_out, proj_z_out} != e) data_errs++;
      end
      if (xfer_cnt > 0 && (cyc - last_xfer_cyc) < min_gap) min_gap = cyc - last_xfer_cyc;
      last_xfer_cyc = cyc;
      xfer_cnt++;
      done_q.push_back(cyc + 5);
    end
    if (frame_done_out) begin
      done_pulses++;
      done_cyc = cyc;
    end
    prev_valid = proj_valid_out;
    prev_ready = proj_ready_in;
    prev_xyz   = {proj_x_out, proj_y_out, proj_z_out};
  end

  // ---------------- driver tasks ----------------
  task automatic setup_frame(input int exp_n);
    exp_q.delete();
    done_q.delete();
    for (int i = 0; i < exp_n; i++) exp_q.push_back({fx(i), fy(i), fz(i)});
    rd_cnt = 0; last_addr = -1; addr_errs = 0; xfer_cnt = 0; data_errs = 0;
    proto_errs = 0; done_pulses = 0; done_cyc = 0; min_gap = 1000; valid_cnt = 0;
  endtask

  int start_cyc;
  task automatic start_frame(input int n);
    @(posedge clk); #1;
    frame_start_in    = 1'b1;
    particle_count_in = CW'(n);
    start_cyc         = cyc;
    @(posedge clk); #1;
    frame_start_in    = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_pulses == 0 && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    check("frame_done_seen", done_pulses > 0, 1);
    repeat (8) @(negedge clk);
    #1;
  endtask

  task automatic wait_xfer(input int n, input int budget);
    int k = 0;
    while (xfer_cnt < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    check("xfer_reached", xfer_cnt >= n, 1);
  endtask

  task automatic check_frame(input string tag, input int exp_n);
    check({tag, "_xfers"},     xfer_cnt, exp_n);
    check({tag, "_reads"},     rd_cnt, exp_n);
    check({tag, "_last_addr"}, last_addr, exp_n - 1);
    check({tag, "_addr_errs"}, addr_errs, 0);
    check({tag, "_data_errs"}, data_errs, 0);
    check({tag, "_sb_left"},   exp_q.size(), 0);
    check({tag, "_proto"},     proto_errs, 0);
    check({tag, "_done_cnt"},  done_pulses, 1);
    check({tag, "_issued"},    issued_count_out, exp_n);
    check({tag, "_completed"}, completed_count_out, exp_n);
    check({tag, "_busy_low"},  busy_out, 0);
    if (exp_n >= 2) check({tag, "_min_gap"}, min_gap, RL + 2);
  endtask

  typedef struct {
    int count;
    int exp_n;
  } vec_t;

  vec_t vecs[6];

  logic [15:0] hold_x;
  int          hold_errs;

  initial begin
    vecs[0] = '{count: 3,   exp_n: 3};
    vecs[1] = '{count: 1,   exp_n: 1};
    vecs[2] = '{count: 5,   exp_n: 5};
    vecs[3] = '{count: 64,  exp_n: 64};
    vecs[4] = '{count: 200, exp_n: 64};
    vecs[5] = '{count: 100, exp_n: 64};

    // Reset before any clock edge.
    #1 rst_n_in = 1'b0;
    #2;
    check("reset_outputs_async", all_outs(), 0);
    repeat (3) @(posedge clk);
    #1 rst_n_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_reset_outputs", all_outs(), 0);

    // Table of frame sizes, projector always ready.
    for (int v = 0; v < 6; v++) begin
      setup_frame(vecs[v].exp_n);
      start_frame(vecs[v].count);
      check($sformatf("v%0d_busy_start", v), busy_out, 1);
      wait_done(2000);
      check_frame($sformatf("v%0d", v), vecs[v].exp_n);
    end

    // Empty frame, then done pulses while idle must be ignored.
    setup_frame(0);
    start_frame(0);
    wait_done(50);
    check("zero_done_latency", done_cyc - start_cyc, 2);
    check("zero_reads", rd_cnt, 0);
    check("zero_valid", valid_cnt, 0);
    check("zero_done_cnt", done_pulses, 1);
    check("zero_issued", issued_count_out, 0);
    done_q.push_back(cyc + 1);
    done_q.push_back(cyc + 3);
    repeat (6) @(negedge clk);
    #1;
    check("idle_done_ignored", completed_count_out, 0);

    // Backpressure: projector stalls for 10 cycles while valid.
    setup_frame(2);
    proj_ready_in = 1'b0;
    start_frame(2);
    begin
      int k = 0;
      while (!proj_valid_out && k < 50) begin @(negedge clk); #1; k++; end
    end
    check("bp_valid_seen", proj_valid_out, 1);
    hold_x = proj_x_out;
    hold_errs = 0;
    repeat (10) begin
      @(negedge clk);
      if (!proj_valid_out || proj_x_out != hold_x) hold_errs++;
    end
    check("bp_hold_errs", hold_errs, 0);
    check("bp_x_value", hold_x, fx(0));
    check("bp_no_xfer", xfer_cnt, 0);
    @(posedge clk); #1;
    proj_ready_in = 1'b1;
    wait_done(200);
    check_frame("bp", 2);

    // Overrun: second frame start during a frame.
    check("overrun_clear", overrun_out, 0);
    setup_frame(3);
    start_frame(3);
    wait_xfer(1, 100);
    @(posedge clk); #1;
    frame_start_in = 1'b1;
    particle_count_in = CW'(5);
    @(posedge clk); #1;
    frame_start_in = 1'b0;
    check("overrun_set", overrun_out, 1);
    wait_done(300);
    check_frame("ovr", 3);
    check("overrun_sticky", overrun_out, 1);

    // Saturation: more completions than particles.
    setup_frame(2);
    start_frame(2);
    wait_xfer(1, 100);
    done_q.delete();
    done_q.push_back(last_xfer_cyc + 1);
    done_q.push_back(last_xfer_cyc + 2);
    done_q.push_back(last_xfer_cyc + 3);
    wait_done(200);
    check("sat_completed", completed_count_out, 2);
    check("sat_issued", issued_count_out, 2);
    check("sat_done_cnt", done_pulses, 1);

    // Final completion in the same cycle as the final transfer.
    setup_frame(2);
    start_frame(2);
    wait_xfer(1, 100);
    done_q.delete();
    done_q.push_back(last_xfer_cyc + 2);
    done_q.push_back(last_xfer_cyc + 4);
    wait_done(200);
    check("same_cyc_done_latency", done_cyc - last_xfer_cyc, 3);
    check("same_cyc_completed", completed_count_out, 2);
    check("same_cyc_done_cnt", done_pulses, 1);

    // Reset while draining: everything clears at once, no frame_done.
    setup_frame(3);
    start_frame(3);
    wait_xfer(3, 200);
    @(negedge clk);
    #2 rst_n_in = 1'b0;
    #1;
    check("drain_reset_outputs", all_outs(), 0);
    repeat (4) @(negedge clk);
    check("drain_reset_no_done", done_pulses, 0);
    @(posedge clk); #1;
    rst_n_in = 1'b1;
    repeat (3) @(posedge clk);
    setup_frame(3);
    start_frame(3);
    wait_done(300);
    check_frame("after_rst", 3);
    check("after_rst_overrun", overrun_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/projection_scheduler.md
PROJECTION_SCHEDULER -- requirements
Module: projection_scheduler

Interface
REQ-001 SHALL have parameter NUM_PARTICLES, default 64, meaning maximum particles per frame.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, meaning position-memory address width, equal to $clog2(NUM_PARTICLES).
REQ-003 SHALL have parameter READ_LATENCY, default 2, meaning cycles from mem_rd_en_out to valid mem_*_in data.
REQ-004 SHALL have ports, in this order:
  clk_in  input  1  sole clock, rising edge.
  rst_n_in  input  1  reset, asynchronous, active-low.
  frame_start_in  input  1  one-cycle pulse that begins a frame.
  particle_count_in  input  ADDR_WIDTH+1  particles this frame, sampled on accepted frame_start_in.
  mem_rd_en_out  output  1  position-memory read strobe.
  mem_addr_out  output  ADDR_WIDTH  particle index being read.
  mem_x_in / mem_y_in / mem_z_in  input  16 each  fixed-point position read data.
  proj_valid_out  output  1  position valid to projector.
  proj_ready_in  input  1  projector ready.
  proj_x_out / proj_y_out / proj_z_out  output  16 each  position to projector.
  proj_done_in  input  1  projector result-valid pulse, one per particle.
  busy_out  output  1  frame in progress.
  frame_done_out  output  1  one-cycle pulse when the frame completes.
  overrun_out  output  1  sticky flag: frame_start_in arrived while busy.
  issued_count_out / completed_count_out  output  ADDR_WIDTH+1 each  particles sent to / returned from projector this frame.

Function
REQ-005 SHALL implement states IDLE, FETCH, PRESENT, DRAIN, DONE.
REQ-006 IDLE: frame_start_in with particle_count_in > 0 SHALL latch the count (clamped to NUM_PARTICLES), clear both counters, zero the index, and go to FETCH; busy_out high from the next cycle.
REQ-007 IDLE: frame_start_in with particle_count_in == 0 SHALL go directly to DONE.
REQ-008 FETCH: SHALL assert mem_rd_en_out for exactly one cycle with mem_addr_out = index, wait READ_LATENCY cycles, register mem_*_in into proj_*_out, then go to PRESENT.
REQ-009 PRESENT: proj_valid_out SHALL be high and proj_*_out stable until a cycle with proj_valid_out && proj_ready_in (transfer).
REQ-010 On transfer: issued_count increments; proj_valid_out drops next cycle; if issued_count becomes the latched count, go to DRAIN, else index increments and go to FETCH.
REQ-011 proj_valid_out SHALL never be high outside PRESENT; at most one transfer per PRESENT entry.
REQ-012 completed_count SHALL increment on each proj_done_in while busy_out is high; proj_done_in in IDLE or DONE SHALL be ignored.
REQ-013 completed_count SHALL saturate at the latched count; extra proj_done_in pulses are ignored.
REQ-014 DRAIN: when completed_count equals the latched count, SHALL go to DONE; this includes the case where the final proj_done_in arrives in the same cycle as the final transfer.
REQ-015 DONE: frame_done_out SHALL be high for exactly one cycle, busy_out low, then return to IDLE; counters hold their values until the next frame start.
REQ-016 frame_start_in while in any state other than IDLE SHALL be ignored and SHALL set overrun_out.
REQ-017 Minimum per-particle issue interval SHALL be READ_LATENCY+2 cycles at a continuously ready projector.

Reset
REQ-018 While rst_n_in is low, SHALL go to IDLE immediately, regardless of the clock.
REQ-019 While rst_n_in is low, all outputs, counters, index and the latched count SHALL be 0.
REQ-020 Reset asserted mid-frame SHALL abandon the frame with no frame_done_out pulse; release SHALL be synchronised internally to clk_in.

Structure
REQ-021 State enum and the default fixed-point width (16) SHALL live in shared package render_pkg.
REQ-022 A sub-module read_latency_pipe (a shift register of depth READ_LATENCY for the read-valid bit) is natural; everything else is flat.

Verification
REQ-023 count=3, projector ready every cycle, proj_done_in 5 cycles after each transfer -> reads at addresses 0,1,2; exactly 3 transfers; one frame_done_out pulse; issued=completed=3.
REQ-024 count=0 -> frame_done_out 2 cycles after frame_start_in; no mem_rd_en_out; no proj_valid_out.
REQ-025 count=2, proj_ready_in held low for 10 cycles in PRESENT -> proj_valid_out and proj_x_out held constant for those 10 cycles; one transfer once ready goes high.
REQ-026 count=200 with NUM_PARTICLES=64 -> exactly 64 transfers; last address 63.
REQ-027 frame_start_in mid-frame -> overrun_out set and stays set; current frame unaffected; frame_done_out pulses exactly once.
REQ-028 rst_n_in low during DRAIN -> all outputs 0 before the next clock edge; no frame_done_out; a new frame afterwards completes normally.
